// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: shift-add MUL/MULH and restoring DIVU/REMU,
// one bit per cycle, with a valid/ack result handshake.
module mdu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       opcode,
   input  logic [WIDTH-1:0] arg1,
   input  logic [WIDTH-1:0] arg2,
   output logic             ready,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   input  logic             result_ack,
   output logic             overflow,
   output logic             div_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [1:0] OP_MUL  = 2'd0;
   localparam logic [1:0] OP_MULH = 2'd1;
   localparam logic [1:0] OP_DIVU = 2'd2;

   logic [1:0]         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_valid;
   logic               r_dz;
   logic [1:0]         r_op;
   logic [WIDTH-1:0]   r_a;
   logic [2*WIDTH-1:0] r_prod;
   logic [WIDTH-1:0]   r_quo;
   logic [WIDTH:0]     r_rem;

   logic               w_accept;
   logic               w_dz_req;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH+1:0]   w_shift;
   logic               w_ge;
   logic [WIDTH:0]     w_diff;

   assign w_accept = start && (r_state == S_IDLE);
   assign w_dz_req = opcode[1] && (arg2 == '0);

   // Shift-add step: add multiplicand when the current multiplier bit is set.
   assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + ({1'b0, r_a} & {(WIDTH+1){r_prod[0]}});

   // Restoring step: bring in the next dividend bit, subtract if it fits.
   assign w_shift = {r_rem, r_quo[WIDTH-1]};
   assign w_ge    = (w_shift >= {2'b00, r_a});
   assign w_diff  = w_shift[WIDTH:0] - {1'b0, r_a};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_valid <= 1'b0;
               if (start) begin
                  r_dz <= w_dz_req;
                  if (w_dz_req) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_BUSY;
                     r_cnt   <= CNT_W'(WIDTH);
                  end
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) r_state <= S_DONE;
            end
            S_DONE: begin
               // result_valid is registered one edge after entering DONE.
               if (result_ack && r_valid) begin
                  r_state <= S_IDLE;
                  r_valid <= 1'b0;
               end else begin
                  r_valid <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_op   <= opcode;
         r_a    <= opcode[1] ? arg2 : arg1;
         r_prod <= {{WIDTH{1'b0}}, arg2};
         // A zero divisor preloads the defined quotient/remainder directly.
         r_quo  <= w_dz_req ? {WIDTH{1'b1}} : arg1;
         r_rem  <= w_dz_req ? {1'b0, arg1} : '0;
      end else if (r_state == S_BUSY) begin
         if (!r_op[1]) begin
            r_prod <= {w_sum, r_prod[WIDTH-1:1]};
         end else begin
            r_rem <= w_ge ? w_diff : w_shift[WIDTH:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
         end
      end
   end

   assign ready        = (r_state == S_IDLE);
   assign result_valid = r_valid;
   assign overflow     = r_valid && (r_op == OP_MUL) && (r_prod[2*WIDTH-1:WIDTH] != '0);
   assign div_zero     = r_valid && r_dz;

   always_comb begin
      result = '0;
      if (r_valid) begin
         case (r_op)
            OP_MUL:  result = r_prod[WIDTH-1:0];
            OP_MULH: result = r_prod[2*WIDTH-1:WIDTH];
            OP_DIVU: result = r_quo;
            default: result = r_rem[WIDTH-1:0];
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq (WIDTH=16): directed vector table, handshake/reset
// sequences, and randomized operations against an arithmetic reference model.
module tb_mdu_seq;

   localparam int W = 16;

   logic         clk;
   logic         rst;
   logic         start;
   logic [1:0]   opcode;
   logic [W-1:0] arg1;
   logic [W-1:0] arg2;
   logic         ready;
   logic [W-1:0] result;
   logic         result_valid;
   logic         result_ack;
   logic         overflow;
   logic         div_zero;

   int n_tests = 0;
   int n_fail  = 0;

   mdu_seq #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .opcode       (opcode),
      .arg1         (arg1),
      .arg2         (arg2),
      .ready        (ready),
      .result       (result),
      .result_valid (result_valid),
      .result_ack   (result_ack),
      .overflow     (overflow),
      .div_zero     (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         ov;
      logic         dz;
      int           lat;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] res, input logic ov, input logic dz, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res; v.ov = ov; v.dz = dz; v.lat = lat;
      return v;
   endfunction

   // Reference: full-width product and plain integer division.
   function automatic vec_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      vec_t v;
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      v.op = op; v.a = a; v.b = b;
      v.ov = 1'b0; v.dz = 1'b0; v.lat = W + 1;
      case (op)
         2'd0: begin v.res = p[W-1:0]; v.ov = (p[2*W-1:W] != 0); end
         2'd1: v.res = p[2*W-1:W];
         2'd2: v.res = (b == 0) ? {W{1'b1}} : a / b;
         default: v.res = (b == 0) ? a : a % b;
      endcase
      if (op[1] && b == 0) begin
         v.dz  = 1'b1;
         v.lat = 1;
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      start  = 1'b1;
      opcode = op;
      arg1   = a;
      arg2   = b;
      @(posedge clk); #1;
      start  = 1'b0;
      opcode = 2'($urandom);
      arg1   = W'($urandom);
      arg2   = W'($urandom);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!result_valid && lat < 100);
   endtask

   task automatic do_ack();
      result_ack = 1'b1;
      @(posedge clk); #1;
      result_ack = 1'b0;
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      int lat;
      launch(v.op, v.a, v.b);
      chk({tag, "_ready_low"}, 64'(ready), 64'd0);
      wait_valid(lat);
      chk({tag, "_latency"}, 64'(lat), 64'(v.lat));
      chk({tag, "_result"}, 64'(result), 64'(v.res));
      chk({tag, "_overflow"}, 64'(overflow), 64'(v.ov));
      chk({tag, "_div_zero"}, 64'(div_zero), 64'(v.dz));
      do_ack();
      chk({tag, "_ready_after_ack"}, 64'(ready), 64'd1);
   endtask

   vec_t vecs[12];

   initial begin
      int lat;
      vec_t v;
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;

      vecs[0]  = mk(2'd0, 16'd300,  16'd300,  16'h5F90, 1'b1, 1'b0, 17);
      vecs[1]  = mk(2'd1, 16'd300,  16'd300,  16'h0001, 1'b0, 1'b0, 17);
      vecs[2]  = mk(2'd0, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 17);
      vecs[3]  = mk(2'd2, 16'd1000, 16'd7,    16'd142,  1'b0, 1'b0, 17);
      vecs[4]  = mk(2'd3, 16'd1000, 16'd7,    16'd6,    1'b0, 1'b0, 17);
      vecs[5]  = mk(2'd2, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1);
      vecs[6]  = mk(2'd3, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b1, 1);
      vecs[7]  = mk(2'd0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 17);
      vecs[8]  = mk(2'd1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0, 17);
      vecs[9]  = mk(2'd2, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 17);
      vecs[10] = mk(2'd2, 16'd5,    16'd9,    16'd0,    1'b0, 1'b0, 17);
      vecs[11] = mk(2'd3, 16'd5,    16'd9,    16'd5,    1'b0, 1'b0, 17);

      rst = 1'b0; start = 1'b0; opcode = 2'd0; arg1 = '0; arg2 = '0; result_ack = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("reset_ready", 64'(ready), 64'd1);
      chk("reset_valid", 64'(result_valid), 64'd0);
      chk("reset_result", 64'(result), 64'd0);
      chk("reset_overflow", 64'(overflow), 64'd0);
      chk("reset_div_zero", 64'(div_zero), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

      // Result held in DONE while start and operands toggle without ack.
      launch(2'd0, 16'd300, 16'd300);
      wait_valid(lat);
      chk("hold_latency", 64'(lat), 64'd17);
      for (int i = 0; i < 5; i++) begin
         start  = ~start;
         opcode = 2'($urandom);
         arg1   = W'($urandom);
         arg2   = W'($urandom);
         @(posedge clk); #1;
         chk($sformatf("hold_result_%0d", i), 64'(result), 64'h5F90);
         chk($sformatf("hold_ready_%0d", i), 64'(ready), 64'd0);
         chk($sformatf("hold_valid_%0d", i), 64'(result_valid), 64'd1);
      end
      start = 1'b0;
      do_ack();
      chk("hold_ack_ready", 64'(ready), 64'd1);
      chk("hold_ack_valid", 64'(result_valid), 64'd0);

      // Asynchronous reset in the middle of BUSY abandons the operation.
      launch(2'd0, 16'hFFFF, 16'hFFFF);
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("midrst_ready", 64'(ready), 64'd1);
      chk("midrst_valid", 64'(result_valid), 64'd0);
      chk("midrst_result", 64'(result), 64'd0);
      #1 rst = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (result_valid) lat++;
      end
      chk("midrst_no_result", 64'(lat), 64'd0);
      run_vec("after_rst_mul", mk(2'd0, 16'd3, 16'd4, 16'd12, 1'b0, 1'b0, 17));

      // Randomized operations against the reference model.
      for (int i = 0; i < 30; i++) begin
         rop = 2'($urandom);
         ra  = W'($urandom);
         rb  = ($urandom_range(0, 4) == 0) ? W'(0) : W'($urandom);
         if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 15));
         v = model(rop, ra, rb);
         run_vec($sformatf("rnd%0d_op%0d_%0h_%0h", i, rop, ra, rb), v);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits; legal values are 4 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: operation request.
REQ-005 The block SHALL have port opcode, input, 2 bits: 00 MUL (low product half), 01 MULH (high product half), 10 DIVU (unsigned quotient), 11 REMU (unsigned remainder).
REQ-006 The block SHALL have ports arg1 and arg2, input, WIDTH bits each: unsigned operands; for DIVU and REMU, arg1 is the dividend and arg2 the divisor.
REQ-007 The block SHALL have port ready, output, 1 bit: high when a request can be accepted.
REQ-008 The block SHALL have port result, output, WIDTH bits: operation result.
REQ-009 The block SHALL have port result_valid, output, 1 bit: result and flags are valid.
REQ-010 The block SHALL have port result_ack, input, 1 bit: consumer has taken the result.
REQ-011 The block SHALL have port overflow, output, 1 bit: for MUL, the high product half is nonzero.
REQ-012 The block SHALL have port div_zero, output, 1 bit: DIVU or REMU was issued with arg2 == 0.

Function
REQ-013 The block SHALL implement a three-state FSM with states IDLE, BUSY and DONE; ready SHALL be high only in IDLE.
REQ-014 A request SHALL be accepted on a rising edge where start=1 and ready=1; at that edge opcode, arg1 and arg2 SHALL be captured, and later input changes SHALL NOT affect the operation.
REQ-015 On acceptance with a valid operation, the FSM SHALL go IDLE -> BUSY and load an iteration counter with WIDTH.
REQ-016 MUL and MULH SHALL use iterative shift-add, one multiplier bit per cycle, into a 2*WIDTH-bit product register.
REQ-017 DIVU and REMU SHALL use iterative restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
REQ-018 BUSY SHALL last exactly WIDTH cycles; at the end of the last cycle the FSM SHALL go to DONE.
REQ-019 result_valid SHALL rise on the (WIDTH+1)th rising edge after the accepting edge.
REQ-020 If DIVU or REMU is accepted with arg2 == 0, the FSM SHALL go IDLE -> DONE directly, so result_valid rises 1 edge after acceptance.
REQ-021 On divide by zero, result SHALL be all ones for DIVU and the captured arg1 for REMU, with div_zero=1.
REQ-022 In DONE, the block SHALL assert result_valid=1 and hold result, overflow and div_zero stable until a rising edge with result_ack=1, which SHALL return the FSM to IDLE.
REQ-023 start SHALL be ignored while the FSM is in BUSY or DONE, and no request SHALL be queued.
REQ-024 result_ack SHALL be ignored outside DONE.
REQ-025 overflow SHALL be 0 for MULH, DIVU and REMU.
REQ-026 div_zero SHALL be 0 for MUL and MULH.
REQ-027 All arithmetic SHALL be modulo the stated register widths, with no sign extension.

Reset
REQ-028 While rst=1, the block SHALL immediately force the FSM to IDLE, regardless of clk.
REQ-029 While rst=1, the block SHALL force ready=1, result_valid=0, result=0, overflow=0, div_zero=0, and clear the counter.
REQ-030 A reset asserted during BUSY or DONE SHALL abandon the operation with no result produced.
REQ-031 The first request after reset is released SHALL be accepted normally.

Verification (WIDTH=16)
REQ-032 MUL, arg1=300, arg2=300 -> result=0x5F90, overflow=1, result_valid rises on edge 17 after acceptance.
REQ-033 MULH, same operands -> result=0x0001, overflow=0; MUL with arg1=0xFFFF and arg2=0x0001 -> result=0xFFFF, overflow=0.
REQ-034 DIVU with arg1=1000, arg2=7 -> result=142; REMU with the same operands -> result=6; div_zero=0 in both cases.
REQ-035 DIVU with arg1=0x1234, arg2=0 -> result=0xFFFF, div_zero=1, result_valid on edge 1 after acceptance; REMU with the same operands -> result=0x1234.
REQ-036 Hold result_ack=0 for 5 cycles in DONE while toggling start and the operands -> result is unchanged and ready=0; assert result_ack -> ready=1 on the next edge.
REQ-037 Assert rst asynchronously 5 cycles into BUSY -> ready=1 and result_valid=0 before the next clk edge; a following MUL 3*4 -> result=12.
